// File: rtl/order_ingress_throttle.sv
// Ingress FIFO and token-bucket pacer in front of order_manager, with a risk kill-switch.
// CANCELs bypass the token check but never overtake older orders in the FIFO.
module order_ingress_throttle #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int TOKEN_MAX     = 8,
  parameter int REFILL_PERIOD = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_symbol,
  input  logic [DATA_WIDTH-1:0]         in_price,
  input  logic [DATA_WIDTH-1:0]         in_volume,
  input  logic [DATA_WIDTH-1:0]         in_id,
  input  logic [7:0]                    in_type,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_symbol,
  output logic [DATA_WIDTH-1:0]         out_price,
  output logic [DATA_WIDTH-1:0]         out_volume,
  output logic [DATA_WIDTH-1:0]         out_id,
  output logic [7:0]                    out_type,
  input  logic                          risk_violation,
  input  logic                          halt_clear,
  input  logic                          flush,
  output logic                          halted,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [$clog2(TOKEN_MAX):0]    tokens,
  output logic [15:0]                   drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TOKEN_MAX) + 1;
  localparam int RW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
  localparam int EW = 8 + 4 * DATA_WIDTH;

  localparam logic [7:0] TYPE_BUY    = 8'h01;
  localparam logic [7:0] TYPE_SELL   = 8'h02;
  localparam logic [7:0] TYPE_CANCEL = 8'h03;

  // Entry layout: {type, symbol, price, volume, id}
  logic [EW-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tokens_q, tokens_d;
  logic [RW-1:0] refill_q, refill_d;
  logic [15:0]   drop_q, drop_d;
  logic          halted_q, halted_d;
  logic          out_valid_q, out_valid_d;
  logic [EW-1:0] out_entry_q, out_entry_d;

  logic          fifo_empty, fifo_full, accept, type_ok, wr_en;
  logic          slot_free, head_cancel, load, consume, refill_wrap, halt_drop;
  logic [EW-1:0] head, wr_entry;
  logic [1:0]    drop_inc;
  logic [16:0]   drop_sum;

  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CW'(FIFO_DEPTH));
  assign in_ready    = !fifo_full && !flush;
  assign accept      = in_valid && in_ready;
  assign type_ok     = (in_type == TYPE_BUY) || (in_type == TYPE_SELL) || (in_type == TYPE_CANCEL);
  assign wr_en       = accept && type_ok;
  assign wr_entry    = {in_type, in_symbol, in_price, in_volume, in_id};

  assign head        = mem[rd_ptr_q];
  assign head_cancel = (head[EW-1 -: 8] == TYPE_CANCEL);
  assign slot_free   = !out_valid_q || out_ready;
  // A halt discard owns the output register this edge, so it also blocks a load.
  assign load        = slot_free && !fifo_empty && !halted_q && !flush && !risk_violation
                       && (head_cancel || (tokens_q != '0));
  assign consume     = load && !head_cancel;
  assign refill_wrap = (refill_q == RW'(REFILL_PERIOD - 1));
  assign halt_drop   = risk_violation && out_valid_q && !flush;

  assign drop_inc    = {1'b0, halt_drop} + {1'b0, accept && !type_ok};
  assign drop_sum    = {1'b0, drop_q} + 17'(drop_inc);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    tokens_d    = tokens_q;
    refill_d    = refill_wrap ? '0 : refill_q + 1'b1;
    drop_d      = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    halted_d    = halted_q;
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (load)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, load})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    if (refill_wrap && !consume) begin
      tokens_d = (tokens_q == TW'(TOKEN_MAX)) ? tokens_q : tokens_q + 1'b1;
    end else if (consume && !refill_wrap) begin
      tokens_d = tokens_q - 1'b1;
    end

    if (risk_violation) begin
      halted_d = 1'b1;
    end else if (halt_clear) begin
      halted_d = 1'b0;
    end

    if (flush || halt_drop) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_entry_d = head;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tokens_q    <= TW'(TOKEN_MAX);
      refill_q    <= '0;
      drop_q      <= '0;
      halted_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tokens_q    <= tokens_d;
      refill_q    <= refill_d;
      drop_q      <= drop_d;
      halted_q    <= halted_d;
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_type   = out_entry_q[EW-1 -: 8];
  assign out_symbol = out_entry_q[4*DATA_WIDTH-1 -: DATA_WIDTH];
  assign out_price  = out_entry_q[3*DATA_WIDTH-1 -: DATA_WIDTH];
  assign out_volume = out_entry_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign out_id     = out_entry_q[DATA_WIDTH-1:0];
  assign halted     = halted_q;
  assign fifo_count = count_q;
  assign tokens     = tokens_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_order_ingress_throttle.sv
// Directed bench for order_ingress_throttle: a vector table for single orders plus
// hand-written sequences for burst pacing, backpressure, halt, CANCEL exemption and flush.
module tb_order_ingress_throttle;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_symbol, in_price, in_volume, in_id;
  logic [DW-1:0] out_symbol, out_price, out_volume, out_id;
  logic [7:0]    in_type, out_type;
  logic          risk_violation, halt_clear, flush, halted;
  logic [4:0]    fifo_count;
  logic [3:0]    tokens;
  logic [15:0]   drop_count;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc   = 0;
  logic [15:0]   exp_drop;

  always #5 clk = ~clk;

  order_ingress_throttle #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(16), .TOKEN_MAX(8), .REFILL_PERIOD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_symbol(in_symbol), .in_price(in_price), .in_volume(in_volume), .in_id(in_id),
    .in_type(in_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_symbol(out_symbol), .out_price(out_price), .out_volume(out_volume), .out_id(out_id),
    .out_type(out_type),
    .risk_violation(risk_violation), .halt_clear(halt_clear), .flush(flush),
    .halted(halted), .fifo_count(fifo_count), .tokens(tokens), .drop_count(drop_count)
  );

  typedef struct {
    logic [7:0]  typ;
    logic [31:0] id;
    logic        issue;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] sym_of(input logic [31:0] id);
    return {id[15:0], id[31:16]};
  endfunction
  function automatic logic [31:0] price_of(input logic [31:0] id);
    return id + 32'h0000_1000;
  endfunction
  function automatic logic [31:0] vol_of(input logic [31:0] id);
    return ~id;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Wait so that the next edge lands on a known refill phase (wrap edges are cyc%4==0).
  task automatic align(input int p);
    while (cyc % 4 != p) tick();
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] t, input logic [31:0] id);
    in_valid  = v;
    in_type   = t;
    in_id     = id;
    in_symbol = sym_of(id);
    in_price  = price_of(id);
    in_volume = vol_of(id);
  endtask

  initial begin
    logic [19:0] sched;
    logic [31:0] base;
    logic        took;
    int          k, acc, n, c;

    vecs[0] = '{8'h01, 32'h1000_0001, 1'b1};
    vecs[1] = '{8'h02, 32'h1000_0002, 1'b1};
    vecs[2] = '{8'h03, 32'h1000_0003, 1'b1};
    vecs[3] = '{8'h07, 32'h1000_0004, 1'b0};
    vecs[4] = '{8'h00, 32'h1000_0005, 1'b0};
    vecs[5] = '{8'hFF, 32'h1000_0006, 1'b0};
    vecs[6] = '{8'h02, 32'h1000_0007, 1'b1};

    // Reset held for 3 clocks with in_valid asserted
    rst_n = 1'b0; out_ready = 1'b0; risk_violation = 1'b0; halt_clear = 1'b0; flush = 1'b0;
    drive(1'b1, 8'h01, 32'hDEAD_0000);
    idle(3);
    rst_n = 1'b1;
    in_valid = 1'b0;
    cyc = 0;
    exp_drop = 16'd0;
    $display("reset released");
    check("rst_out_valid", out_valid, 0);
    check("rst_tokens", tokens, 8);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_halted", halted, 0);
    check("rst_drop", drop_count, 0);
    check("rst_in_ready", in_ready, 1);

    // Single BUY
    out_ready = 1'b1;
    align(0);
    drive(1'b1, 8'h01, 32'h1234_5678);
    in_symbol = 32'h4141_5054;
    in_price  = 32'h9600_0000;
    tick();
    in_valid = 1'b0;
    check("single_no_bypass", out_valid, 0);
    check("single_fifo1", fifo_count, 1);
    tick();
    $display("single: valid=%0d id=0x%0h tokens=%0d", out_valid, out_id, tokens);
    check("single_valid", out_valid, 1);
    check("single_id", out_id, 32'h1234_5678);
    check("single_sym", out_symbol, 32'h4141_5054);
    check("single_price", out_price, 32'h9600_0000);
    check("single_type", out_type, 8'h01);
    check("single_tokens7", tokens, 7);
    k = 0;
    while (tokens != 4'd8 && k < 4) begin tick(); k++; end
    check("single_refill", tokens, 8);

    // Vector table: each order from idle, out_ready high
    foreach (vecs[i]) begin
      idle(6);
      drive(1'b1, vecs[i].typ, vecs[i].id);
      tick();
      in_valid = 1'b0;
      check("vec_no_bypass", out_valid, 0);
      check("vec_fifo_after_accept", fifo_count, {4'd0, vecs[i].issue});
      tick();
      if (!vecs[i].issue) exp_drop++;
      $display("vec %0d: type=0x%0h valid=%0d id=0x%0h drop=%0d", i, vecs[i].typ, out_valid, out_id, drop_count);
      check("vec_issue", out_valid, vecs[i].issue);
      if (vecs[i].issue) begin
        check("vec_id", out_id, vecs[i].id);
        check("vec_type", out_type, vecs[i].typ);
        check("vec_sym", out_symbol, sym_of(vecs[i].id));
        check("vec_price", out_price, price_of(vecs[i].id));
        check("vec_vol", out_volume, vol_of(vecs[i].id));
      end
      check("vec_drop", drop_count, exp_drop);
    end

    // Burst of 12 BUYs then a CANCEL while the bucket is empty
    idle(40);
    out_ready = 1'b1;
    base  = 32'h2000_0000;
    sched = 20'h517FE;
    k = 0;
    align(0);
    drive(1'b1, 8'h01, base);
    for (int r = 0; r < 20; r++) begin
      tick();
      if (r < 11)       drive(1'b1, 8'h01, base + 32'(r + 1));
      else if (r == 16) drive(1'b1, 8'h03, 32'hABCD_EF00);
      else              in_valid = 1'b0;
      $display("burst edge %0d: valid=%0d id=0x%0h tokens=%0d", r, out_valid, out_id, tokens);
      check("burst_valid", out_valid, sched[r]);
      if (sched[r]) begin
        if (k < 12) begin
          check("burst_id", out_id, base + 32'(k));
        end else begin
          check("cancel_id", out_id, 32'hABCD_EF00);
          check("cancel_type", out_type, 8'h03);
        end
        k++;
      end
      if (r == 10) check("burst_tokens_empty", tokens, 0);
      if (r == 11) check("burst_refill1", tokens, 1);
      if (r == 16) check("burst_end_tokens", tokens, 0);
      if (r == 18) check("cancel_tokens_untouched", tokens, 0);
      if (r == 19) check("burst_refill_running", tokens, 1);
    end

    // Backpressure: fill output register plus FIFO
    idle(40);
    out_ready = 1'b0;
    base = 32'h3000_0000;
    acc = 0;
    for (int i = 0; i < 25; i++) begin
      if (acc < 18) drive(1'b1, 8'h02, base + 32'(acc));
      else          in_valid = 1'b0;
      took = in_valid && in_ready;
      tick();
      if (took) acc++;
    end
    $display("backpressure: accepted=%0d fifo=%0d in_ready=%0d", acc, fifo_count, in_ready);
    check("bp_accepted", acc, 17);
    check("bp_fifo_full", fifo_count, 16);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_id", out_id, base);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    c = 0;
    while (n < 17 && c < 200) begin
      if (out_valid) begin
        check("bp_order", out_id, base + 32'(n));
        n++;
      end
      tick();
      c++;
    end
    $display("backpressure drain: issued=%0d cycles=%0d", n, c);
    check("bp_drained", n, 17);
    check("bp_paced", c > 20, 1);

    // Halt with 3 queued behind the output register
    idle(40);
    out_ready = 1'b0;
    base = 32'h4000_0000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h01, base + 32'(i));
      tick();
    end
    in_valid = 1'b0;
    check("halt_pre_valid", out_valid, 1);
    check("halt_pre_fifo", fifo_count, 3);
    risk_violation = 1'b1;
    tick();
    risk_violation = 1'b0;
    exp_drop++;
    $display("halt: halted=%0d valid=%0d drop=%0d fifo=%0d", halted, out_valid, drop_count, fifo_count);
    check("halt_set", halted, 1);
    check("halt_discard", out_valid, 0);
    check("halt_drop", drop_count, exp_drop);
    check("halt_fifo_kept", fifo_count, 3);
    out_ready = 1'b1;
    drive(1'b1, 8'h01, base + 32'd4);
    tick();
    in_valid = 1'b0;
    check("halt_accepts", fifo_count, 4);
    idle(3);
    check("halt_holds", out_valid, 0);
    halt_clear = 1'b1;
    tick();
    halt_clear = 1'b0;
    check("halt_cleared", halted, 0);
    n = 1;
    c = 0;
    while (n < 5 && c < 50) begin
      if (out_valid) begin
        check("halt_resume_order", out_id, base + 32'(n));
        n++;
      end
      tick();
      c++;
    end
    check("halt_resume_count", n, 5);
    idle(4);
    risk_violation = 1'b1;
    halt_clear = 1'b1;
    tick();
    risk_violation = 1'b0;
    halt_clear = 1'b0;
    check("risk_beats_clear", halted, 1);
    check("risk_idle_drop", drop_count, exp_drop);
    halt_clear = 1'b1;
    tick();
    halt_clear = 1'b0;
    check("halt_cleared2", halted, 0);

    // Flush with 5 queued
    idle(40);
    out_ready = 1'b0;
    base = 32'h5000_0000;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'h02, base + 32'(i));
      tick();
    end
    check("flush_pre_fifo", fifo_count, 5);
    check("flush_pre_valid", out_valid, 1);
    drive(1'b1, 8'h02, base + 32'd6);
    flush = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    $display("flush: fifo=%0d valid=%0d drop=%0d", fifo_count, out_valid, drop_count);
    check("flush_fifo", fifo_count, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_drop", drop_count, exp_drop);
    check("flush_halted", halted, 0);
    tick();
    check("flush_stays_empty", out_valid, 0);
    out_ready = 1'b1;
    drive(1'b1, 8'h01, base + 32'd7);
    tick();
    in_valid = 1'b0;
    tick();
    check("post_flush_valid", out_valid, 1);
    check("post_flush_id", out_id, base + 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/order_ingress_throttle.md
Name: order_ingress_throttle

Overview:
- Upstream stage of order_manager: buffers orders from the strategy engine in a FIFO and meters them into order_manager's order_valid/order_ready port.
- A token-bucket rate limiter paces BUY/SELL issue; CANCEL orders are exempt from the limiter.
- Provides a kill-switch: a risk_violation from order_manager halts issue until software clears it.

Parameters:
- DATA_WIDTH, 32, width of symbol/price/volume/id fields
- FIFO_DEPTH, 16, ingress FIFO entries (power of 2)
- TOKEN_MAX, 8, bucket capacity and reset fill level
- REFILL_PERIOD, 4, clocks per token refill (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_valid / in_ready  in / out  1 / 1  strategy-side handshake
- in_symbol, in_price, in_volume, in_id  in  DATA_WIDTH each  order fields
- in_type  in  8  01=BUY, 02=SELL, 03=CANCEL; all other values are invalid
- out_valid  out  1  order presented to order_manager (its order_valid)
- out_ready  in  1  order_manager order_ready
- out_symbol, out_price, out_volume, out_id  out  DATA_WIDTH each  registered fields
- out_type  out  8  registered type
- risk_violation  in  1  from order_manager; starts a halt
- halt_clear  in  1  one-cycle pulse that releases a halt
- flush  in  1  one-cycle pulse that empties the FIFO and the output register
- halted  out  1  halt status
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- tokens  out  $clog2(TOKEN_MAX)+1  current bucket level
- drop_count  out  16  saturating count of discarded orders

Behaviour:
- Single clock; all state changes on posedge clk; rst_n is sampled synchronously.
- Reset values:
  - out_valid=0, all out_* fields=0, halted=0.
  - fifo_count=0, tokens=TOKEN_MAX, drop_count=0.
  - Refill counter=0, FIFO pointers=0.
- in_ready = (fifo_count < FIFO_DEPTH) && !flush. It is not gated by halted.
- Accept occurs on in_valid && in_ready at an edge.
  - Types 01/02/03 are written to the FIFO tail.
  - Any other type is consumed but not written, and drop_count increments by 1, saturating at 0xFFFF.
- Pointers wrap modulo FIFO_DEPTH. A simultaneous write and read leaves fifo_count unchanged.
- Output register: "slot free" = !out_valid || (out_valid && out_ready).
- Load rule: at an edge, the FIFO head moves into the output register when all of the following hold:
  - slot free
  - FIFO not empty
  - !halted
  - !flush
  - head is CANCEL, or tokens>0
- When a BUY/SELL loads, tokens decrements. A CANCEL load does not touch tokens.
- Latency: an order accepted into an empty FIFO at edge k is visible on out_valid after edge k+1 (one clock). There is no bypass.
- out_valid and out_* stay stable until out_ready is sampled high. Back-to-back issue at one order per clock is possible while tokens last.
- Refill:
  - The counter runs 0..REFILL_PERIOD-1 and wraps.
  - On wrap, tokens increments, saturating at TOKEN_MAX. The counter keeps running while the bucket is full.
  - If a refill and a consume happen at the same edge, tokens is unchanged.
- Halt:
  - risk_violation sampled high sets halted=1 at that edge.
  - At the same edge, a valid output register is discarded: out_valid goes to 0 and drop_count increments by 1.
  - The FIFO is retained and inputs are still accepted.
  - halt_clear clears halted at the next edge. If risk_violation and halt_clear are high at the same edge, risk_violation wins and halted stays 1.
- Flush:
  - Sets fifo_count=0, resets both pointers and sets out_valid=0 in one edge.
  - No write happens that cycle.
  - Flushed orders do not count toward drop_count.
  - Tokens and halted are unaffected.
- Priority at the output register: flush > halt discard > normal load/hold.
- Order preservation: FIFO order is strictly preserved. A CANCEL never overtakes an older BUY/SELL; if a BUY/SELL at the head is blocked on tokens, it blocks the CANCELs behind it.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with in_valid=1 -> after release out_valid=0, tokens=8, fifo_count=0, halted=0, drop_count=0, in_ready=1.
- Single order: BUY id=0x12345678, sym=0x41415054, price=0x96000000, out_ready=1 -> out_valid high exactly one clock after accept, all fields match, tokens=7, then back to 8 within 4 clocks.
- Burst: 12 BUYs (ids 0x20000000..0x2000000B) offered back-to-back, out_ready=1 -> ids issue in order with no gaps, tokens reach 0, and the remaining orders issue at the refill rate of one per 4 clocks; the run ends with tokens=0 and the refill counter still counting.
- Backpressure: out_ready=0, offer 18 orders -> 17 accepted (1 in output register + 16 in FIFO), fifo_count=16, in_ready=0; then raise out_ready -> all 17 drain in order, paced by tokens.
- Halt: one-cycle risk_violation pulse while out_valid=1 with 3 orders queued -> halted=1, out_valid=0, drop_count=1, fifo_count=3; halt_clear pulse -> issue resumes with the oldest queued order.
- Invalid, CANCEL and flush:
  - in_type=0x07 -> drop_count increments, nothing issued.
  - With tokens=0 and an empty FIFO, a CANCEL id=0xABCDEF00 -> issued one clock after accept.
  - flush with 5 queued -> fifo_count=0, out_valid=0 next cycle, drop_count unchanged.
